// File: rtl/bus_pkg.sv
// Shared definitions for the CPU external bus: handshake states and byte-lane masks.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RD_DATA = 2'd2,
        WR_DONE = 2'd3
    } bus_state_t;

    localparam logic [1:0] LANE_LO = 2'b01;
    localparam logic [1:0] LANE_HI = 2'b10;
    localparam logic [1:0] LANE_W  = 2'b11;

endpackage

// File: rtl/mem_bus_bank.sv
// On-chip word RAM: synchronous read, independent write enable per byte lane.
module mem_bus_bank
    import bus_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        we,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [0:2**ADDR_W-1];

    always_ff @(posedge clk) begin
        if ((we & LANE_LO) != 2'b00) mem[addr][7:0]  <= wdata[7:0];
        if ((we & LANE_HI) != 2'b00) mem[addr][15:8] <= wdata[15:8];
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_bus_target.sv
// Memory-side bus responder: decodes CPU strobes, inserts wait states and serves
// word/byte-lane accesses from the local RAM bank, signalling completion on rdy.
module mem_bus_target
    import bus_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] abus,
    inout  wire  [15:0] dbus,
    input  logic        nmreq,
    input  logic        nrd,
    input  logic        nwr,
    input  logic        nbhe,
    input  logic        nble,
    output logic        rdy,
    output logic        err
);

    localparam logic [3:0] CNT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    bus_state_t        state, next_state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_idx;
    logic [1:0]        lat_lanes;
    logic              lat_wr;

    logic              rd_req, wr_req, both_req, strobe_kept;
    logic [1:0]        req_lanes;
    logic [ADDR_W-1:0] bank_addr;
    logic [1:0]        bank_we;
    logic [15:0]       rdata;
    logic              unused_abus;

    assign rd_req      = !nmreq && !nrd && nwr;
    assign wr_req      = !nmreq && !nwr && nrd;
    assign both_req    = !nmreq && !nrd && !nwr;
    assign req_lanes   = {~nbhe, ~nble};
    assign strobe_kept = lat_wr ? !nwr : !nrd;
    assign unused_abus = ^{abus[15:ADDR_W+1], abus[0]};

    // In IDLE the bank follows the live address so a zero-wait access can complete on the accepting edge.
    always_comb begin
        next_state = state;
        bank_addr  = lat_idx;
        bank_we    = 2'b00;
        case (state)
            IDLE: begin
                bank_addr = abus[ADDR_W:1];
                if (rd_req) begin
                    next_state = (WAIT_STATES == 0) ? RD_DATA : WAIT;
                end else if (wr_req) begin
                    if (WAIT_STATES == 0) begin
                        bank_we    = req_lanes;
                        next_state = WR_DONE;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (nmreq || !strobe_kept) begin
                    next_state = IDLE;
                end else if (cnt == CNT_LAST) begin
                    if (lat_wr) begin
                        bank_we    = lat_lanes;
                        next_state = WR_DONE;
                    end else begin
                        next_state = RD_DATA;
                    end
                end
            end
            RD_DATA: if (nrd || nmreq) next_state = IDLE;
            WR_DONE: if (nwr || nmreq) next_state = IDLE;
        endcase
        if (!rst) bank_we = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            err       <= 1'b0;
            lat_idx   <= '0;
            lat_lanes <= 2'b00;
            lat_wr    <= 1'b0;
        end else begin
            state <= next_state;
            if (both_req) err <= 1'b1;
            if (state == IDLE && (rd_req || wr_req)) begin
                lat_idx   <= abus[ADDR_W:1];
                lat_lanes <= req_lanes;
                lat_wr    <= wr_req;
                cnt       <= 4'd0;
            end else if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    mem_bus_bank #(.ADDR_W(ADDR_W)) u_bank (
        .clk   (clk),
        .addr  (bank_addr),
        .we    (bank_we),
        .wdata (dbus),
        .rdata (rdata)
    );

    assign rdy  = (state == RD_DATA) || (state == WR_DONE);
    assign dbus = (state == RD_DATA) ? rdata : 16'hzzzz;

endmodule

// File: tb/tb_mem_bus_target.sv
// Bench for mem_bus_target: three builds (1, 3 and 0 wait states) driven by directed
// transactions, with a word/lane memory model and per-cycle output comparison.
module tb_mem_bus_target;

    localparam int N_DUT  = 3;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] abus     [N_DUT];
    logic        nmreq    [N_DUT];
    logic        nrd      [N_DUT];
    logic        nwr      [N_DUT];
    logic        nbhe     [N_DUT];
    logic        nble     [N_DUT];
    logic        drv_en   [N_DUT];
    logic [15:0] drv_data [N_DUT];
    logic [15:0] dbus_obs [N_DUT];
    logic        rdy_obs  [N_DUT];
    logic        err_obs  [N_DUT];

    logic [15:0] mem_model [N_DUT][256];
    logic        exp_rdy   [N_DUT];
    logic        exp_err   [N_DUT];
    logic        exp_drive [N_DUT];
    logic [15:0] exp_data  [N_DUT];

    int   checks = 0;
    int   errors = 0;
    logic chk_on = 1'b0;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        wire [15:0] dbus;
        logic       rdy, err;
        assign dbus        = drv_en[g] ? drv_data[g] : 16'hzzzz;
        assign dbus_obs[g] = dbus;
        assign rdy_obs[g]  = rdy;
        assign err_obs[g]  = err;
        mem_bus_target #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .abus  (abus[g]),
            .dbus  (dbus),
            .nmreq (nmreq[g]),
            .nrd   (nrd[g]),
            .nwr   (nwr[g]),
            .nbhe  (nbhe[g]),
            .nble  (nble[g]),
            .rdy   (rdy),
            .err   (err)
        );
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, want %h", name, $time, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int i, input logic mreq_n, input logic rd_n, input logic wr_n,
                                 input logic bhe_n, input logic ble_n, input logic [15:0] addr);
        nmreq[i] = mreq_n;
        nrd[i]   = rd_n;
        nwr[i]   = wr_n;
        nbhe[i]  = bhe_n;
        nble[i]  = ble_n;
        abus[i]  = addr;
    endtask

    // Model: only the selected byte lanes of the addressed word change.
    task automatic model_write(input int i, input logic [15:0] addr, input logic [15:0] data,
                               input logic hi, input logic lo);
        logic [7:0] idx;
        idx = addr[ADDR_W:1];
        if (hi) mem_model[i][idx][15:8] = data[15:8];
        if (lo) mem_model[i][idx][7:0]  = data[7:0];
    endtask

    task automatic do_write(input int i, input logic [15:0] addr, input logic [15:0] data,
                            input logic hi, input logic lo);
        int ws;
        ws = ws_of(i);
        applyStimulus(i, 1'b0, 1'b1, 1'b0, !hi, !lo, addr);
        drv_en[i]   = 1'b1;
        drv_data[i] = data;
        for (int k = 0; k <= ws; k++) begin
            tick();
            if (k == 0) abus[i] = addr ^ 16'h00FE;
            if (k == ws) begin
                model_write(i, addr, data, hi, lo);
                exp_rdy[i] = 1'b1;
            end
        end
        tick();
        applyStimulus(i, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, addr);
        drv_data[i] = 16'h0000;
        tick();
        exp_rdy[i] = 1'b0;
    endtask

    task automatic do_read(input int i, input logic [15:0] addr, output logic [15:0] got);
        int ws;
        ws = ws_of(i);
        applyStimulus(i, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, addr);
        for (int k = 0; k <= ws; k++) begin
            tick();
            if (k == 0) abus[i] = addr ^ 16'h00FE;
            if (k == ws) begin
                drv_en[i]    = 1'b0;
                exp_rdy[i]   = 1'b1;
                exp_drive[i] = 1'b1;
                exp_data[i]  = mem_model[i][addr[ADDR_W:1]];
            end
        end
        tick();
        got = dbus_obs[i];
        applyStimulus(i, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, addr);
        tick();
        exp_rdy[i]   = 1'b0;
        exp_drive[i] = 1'b0;
        drv_en[i]    = 1'b1;
    endtask

    task automatic do_abort(input int i, input logic [15:0] addr, input logic is_write,
                            input logic [15:0] data, input int edges_before);
        applyStimulus(i, 1'b0, is_write, !is_write, 1'b0, 1'b0, addr);
        drv_data[i] = is_write ? data : 16'h0000;
        repeat (edges_before) tick();
        if (is_write) nwr[i] = 1'b1;
        else          nrd[i] = 1'b1;
        tick();
        applyStimulus(i, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, addr);
        drv_data[i] = 16'h0000;
        repeat (ws_of(i) + 1) tick();
    endtask

    task automatic do_err(input int i, input logic [15:0] addr, input logic [15:0] data);
        applyStimulus(i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, addr);
        drv_data[i] = data;
        tick();
        exp_err[i] = 1'b1;
        applyStimulus(i, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, addr);
        drv_data[i] = 16'h0000;
        tick();
    endtask

    // Every cycle: rdy/err against the model, read data while driven, and release while idle.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < N_DUT; i++) begin
                checkOutput($sformatf("rdy[%0d]", i), {15'd0, rdy_obs[i]}, {15'd0, exp_rdy[i]});
                checkOutput($sformatf("err[%0d]", i), {15'd0, err_obs[i]}, {15'd0, exp_err[i]});
                if (exp_drive[i])
                    checkOutput($sformatf("rdata[%0d]", i), dbus_obs[i], exp_data[i]);
                else if (drv_en[i] && drv_data[i] == 16'h0000)
                    checkOutput($sformatf("release[%0d]", i), dbus_obs[i], 16'h0000);
            end
        end
    end

    initial begin
        logic [15:0] got;
        rst = 1'b0;
        for (int i = 0; i < N_DUT; i++) begin
            applyStimulus(i, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
            drv_en[i]    = 1'b1;
            drv_data[i]  = 16'h0000;
            exp_rdy[i]   = 1'b0;
            exp_err[i]   = 1'b0;
            exp_drive[i] = 1'b0;
            exp_data[i]  = 16'h0000;
        end
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b1;
        tick();

        $display("[TB] word write and read back, 1 wait state");
        do_write(0, 16'h0010, 16'h2399, 1'b1, 1'b1);
        checkOutput("model_word", mem_model[0][8'h08], 16'h2399);
        do_read(0, 16'h0010, got);
        checkOutput("read_word", got, 16'h2399);

        $display("[TB] high-lane byte write");
        do_write(0, 16'h0010, 16'hE355, 1'b1, 1'b0);
        checkOutput("model_hi", mem_model[0][8'h08], 16'hE399);
        do_read(0, 16'h0010, got);
        checkOutput("read_hi", got, 16'hE399);
        do_read(0, 16'h0210, got);
        checkOutput("alias_ws1", got, 16'hE399);

        $display("[TB] simultaneous read and write strobes");
        do_err(0, 16'h0010, 16'h1234);
        do_read(0, 16'h0010, got);
        checkOutput("err_no_write", got, 16'hE399);
        do_write(0, 16'h0020, 16'h5A5A, 1'b1, 1'b1);
        do_read(0, 16'h0020, got);
        checkOutput("read_after_err", got, 16'h5A5A);

        $display("[TB] reset during read data phase");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010);
        tick();
        tick();
        drv_en[0]    = 1'b0;
        exp_rdy[0]   = 1'b1;
        exp_drive[0] = 1'b1;
        exp_data[0]  = mem_model[0][8'h08];
        rst = 1'b0;
        tick();
        for (int i = 0; i < N_DUT; i++) exp_err[i] = 1'b0;
        exp_rdy[0]   = 1'b0;
        exp_drive[0] = 1'b0;
        drv_en[0]    = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
        rst = 1'b1;
        tick();
        do_read(0, 16'h0010, got);
        checkOutput("read_after_rst", got, 16'hE399);

        $display("[TB] 3 wait states: lanes and aborts");
        do_write(1, 16'h0010, 16'h2399, 1'b1, 1'b1);
        do_write(1, 16'h0044, 16'hABCD, 1'b1, 1'b1);
        do_write(1, 16'h0044, 16'h1177, 1'b0, 1'b1);
        do_read(1, 16'h0044, got);
        checkOutput("read_lo", got, 16'hAB77);
        do_abort(1, 16'h0010, 1'b0, 16'h0000, 2);
        do_abort(1, 16'h0010, 1'b1, 16'hFFFF, 1);
        do_read(1, 16'h0010, got);
        checkOutput("abort_no_write", got, 16'h2399);

        $display("[TB] zero wait states");
        do_write(2, 16'h0010, 16'h2399, 1'b1, 1'b1);
        do_write(2, 16'h0010, 16'hE3C3, 1'b1, 1'b0);
        do_read(2, 16'h0010, got);
        checkOutput("read_ws0", got, 16'hE399);
        do_read(2, 16'h0210, got);
        checkOutput("alias_ws0", got, 16'hE399);
        do_write(2, 16'h0010, 16'h7777, 1'b0, 1'b0);
        do_read(2, 16'h0010, got);
        checkOutput("no_lane_write", got, 16'hE399);

        tick();
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
